micro_step_sequencer: RTL and testbench
=======================================

Name: micro_step_sequencer

Overview:
- Sequences the up-to-three ALU micro-steps that the instruction decoder produces for each fetched opcode.
- Captures the opcode and the per-step load/select codes, then issues one datapath step per clk2 cycle. Steps hold while memory stalls.
- After the last step, drives the EIP advance by the instruction length and reopens fetch.
- Sits between the fetch unit, the decoder, and the register-file/ALU datapath.

Parameters:
- STEP_W, 4, width of reg_load/select codes.
- LEN_W, 4, width of instruction-length field.
- EIP_CODE, 4'h4, reg_load code that addresses EIP (suppresses sequential advance).

Ports:
- clk2  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  fetch presents a new opcode.
- fetch_ready  out  1  sequencer accepts opcode (high only in IDLE).
- ope1  in  8  opcode byte from fetch.
- reg_load_1/2/3  in  STEP_W  decoder destination code per step.
- select_1/2/3  in  STEP_W  decoder source code per step.
- num_of_ope  in  LEN_W  decoder instruction length (registered in decoder; valid one cycle after accept).
- stall  in  1  memory wait; freezes current step.
- load_en  out  1  datapath write strobe for current step.
- cur_reg_load  out  STEP_W  destination code of current step.
- cur_select  out  STEP_W  source code of current step.
- step_idx  out  2  current step 1..3, 0 when not stepping.
- eip_inc_en  out  1  EIP += eip_inc this cycle.
- eip_inc  out  LEN_W  instruction length to add.
- busy  out  1  state != IDLE.
- illegal  out  1  unknown opcode accepted.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except fetch_ready=1; all capture registers 0. Reset mid-instruction aborts it with no EIP advance.
- Step-count table on ope1, evaluated at accept:
  - 0x89, 0xb8 → 1 step.
  - 0x55, 0x5d, 0xc3, 0x6a → 2 steps.
  - 0xe2 → 3 steps.
  - Any other value → illegal.
- Accept: fetch_valid & fetch_ready in IDLE. Registers ope1, step count, reg_load_1..3 and select_1..3. Goes to STEP1. Steps beyond the step count are ignored even if the inputs are X.
- STEP1 entry cycle: latches num_of_ope into len_q.
- STEPn (n=1..3):
  - Outputs: cur_reg_load/cur_select = captured code n; step_idx=n; load_en = !stall.
  - Stall=1: hold state, load_en=0, codes stay driven.
  - Stall=0: go to STEPn+1 if n < count, else ADVANCE.
- eip_hit flag: set when any executed step has reg_load == EIP_CODE.
- ADVANCE (1 cycle): eip_inc_en = !eip_hit; eip_inc=len_q; load_en=0; step_idx=0. Then IDLE. Stall is ignored in ADVANCE.
- Latency: an N-step instruction with no stalls occupies N+1 cycles after accept. fetch_ready returns in the cycle after ADVANCE.
- Outputs are registered from state; no combinational path from fetch_valid to any output.
- illegal pulses 1 cycle in the cycle after an illegal accept.
- Illegal handling without the macro: treated as 1-byte NOP: skips steps, goes to ADVANCE with eip_inc=1, eip_inc_en=1.

Optional Feature:
- SEQ_ILLEGAL_TRAP_EN defined:
  - An illegal opcode enters FAULT instead of ADVANCE.
  - FAULT: fetch_ready=0, busy=1, illegal held 1, no load_en or eip_inc_en.
  - Exits only on reset.
- Undefined: NOP behaviour above; no FAULT state is synthesized.

Test Plan:
- Accept 0x89 (num_of_ope=2), stall=0 → cycle+1: load_en=1, cur_reg_load=2, cur_select=2, step_idx=1; cycle+2: eip_inc_en=1, eip_inc=2; cycle+3: fetch_ready=1.
- Accept 0x55, stall=1 for 3 cycles during STEP2 → step_idx=2 held 3 cycles with load_en=0, then one load_en with code 1/1, then eip_inc=1.
- Accept 0xe2 (len 5), with step-3 reg_load=4 → three load_en pulses with codes 1/2, 1/3, 4/2; ADVANCE has eip_inc_en=0.
- Accept 0xc3 → step-1 load code 4 sets eip_hit; ADVANCE has eip_inc_en=0.
- Accept 0xff → without macro: illegal pulse, eip_inc_en=1, eip_inc=1, back to IDLE. With SEQ_ILLEGAL_TRAP_EN: illegal stuck 1, fetch_ready=0 until reset.
- Assert reset during STEP2 of 0x6a → immediate IDLE, all outputs 0, fetch_ready=1, no eip_inc_en ever seen.

Source files
------------

// File: rtl/micro_step_sequencer.sv
// micro_step_sequencer: issues the up-to-three ALU micro-steps that the decoder
// produces for each fetched opcode. It advances EIP by the instruction length
// after the last step and then reopens fetch.
// Optional build macro: SEQ_ILLEGAL_TRAP_EN. When it is defined, an illegal
// opcode traps in FAULT until reset. When it is undefined, an illegal opcode
// retires as a 1-byte NOP.
module micro_step_sequencer #(
  parameter int unsigned       STEP_W   = 4,
  parameter int unsigned       LEN_W    = 4,
  parameter logic [STEP_W-1:0] EIP_CODE = 4'h4
) (
  input  logic              clk2,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [7:0]        ope1,
  input  logic [STEP_W-1:0] reg_load_1,
  input  logic [STEP_W-1:0] reg_load_2,
  input  logic [STEP_W-1:0] reg_load_3,
  input  logic [STEP_W-1:0] select_1,
  input  logic [STEP_W-1:0] select_2,
  input  logic [STEP_W-1:0] select_3,
  input  logic [LEN_W-1:0]  num_of_ope,
  input  logic              stall,
  output logic              load_en,
  output logic [STEP_W-1:0] cur_reg_load,
  output logic [STEP_W-1:0] cur_select,
  output logic [1:0]        step_idx,
  output logic              eip_inc_en,
  output logic [LEN_W-1:0]  eip_inc,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP1,
    S_STEP2,
    S_STEP3,
    S_ADVANCE
`ifdef SEQ_ILLEGAL_TRAP_EN
    , S_FAULT
`endif
  } state_e;

  state_e state_q, state_d;

  logic [1:0]             cnt_q;
  logic [2:0][STEP_W-1:0] rl_q;
  logic [2:0][STEP_W-1:0] sel_q;
  logic [LEN_W-1:0]       len_q;
  logic                   eip_hit_q;
  logic                   first_q;
  logic                   illegal_q;

  logic       accept;
  logic [1:0] cnt_dec;

  // Number of micro-steps for an opcode; 0 marks an unknown opcode.
  function automatic logic [1:0] step_count(input logic [7:0] op);
    case (op)
      8'h89, 8'hb8:               step_count = 2'd1;
      8'h55, 8'h5d, 8'hc3, 8'h6a: step_count = 2'd2;
      8'he2:                      step_count = 2'd3;
      default:                    step_count = 2'd0;
    endcase
  endfunction

  assign cnt_dec = step_count(ope1);
  assign accept  = fetch_valid && (state_q == S_IDLE);

  // State register.
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: step on each unstalled cycle, retire through ADVANCE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_valid) begin
          if (cnt_dec == 2'd0) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d = S_FAULT;
`else
            state_d = S_ADVANCE;
`endif
          end else begin
            state_d = S_STEP1;
          end
        end
      end
      S_STEP1:   if (!stall) state_d = (cnt_q > 2'd1) ? S_STEP2 : S_ADVANCE;
      S_STEP2:   if (!stall) state_d = (cnt_q > 2'd2) ? S_STEP3 : S_ADVANCE;
      S_STEP3:   if (!stall) state_d = S_ADVANCE;
      S_ADVANCE: state_d = S_IDLE;
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_FAULT:   state_d = S_FAULT;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from state. Only load_en also depends on stall.
  always_comb begin
    fetch_ready  = 1'b0;
    busy         = 1'b1;
    load_en      = 1'b0;
    cur_reg_load = '0;
    cur_select   = '0;
    step_idx     = 2'd0;
    eip_inc_en   = 1'b0;
    eip_inc      = '0;
    illegal      = illegal_q;
    case (state_q)
      S_IDLE: begin
        fetch_ready = 1'b1;
        busy        = 1'b0;
      end
      S_STEP1: begin
        load_en      = !stall;
        cur_reg_load = rl_q[0];
        cur_select   = sel_q[0];
        step_idx     = 2'd1;
      end
      S_STEP2: begin
        load_en      = !stall;
        cur_reg_load = rl_q[1];
        cur_select   = sel_q[1];
        step_idx     = 2'd2;
      end
      S_STEP3: begin
        load_en      = !stall;
        cur_reg_load = rl_q[2];
        cur_select   = sel_q[2];
        step_idx     = 2'd3;
      end
      S_ADVANCE: begin
        eip_inc_en = !eip_hit_q;
        eip_inc    = len_q;
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_FAULT: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  // Capture on accept. Codes for steps past the count are zeroed so that
  // undefined decoder outputs never reach the datapath.
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rl_q      <= '0;
      sel_q     <= '0;
      len_q     <= '0;
      eip_hit_q <= 1'b0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && (cnt_dec == 2'd0);
      first_q   <= accept;
      if (accept) begin
        cnt_q     <= cnt_dec;
        rl_q[0]   <= (cnt_dec >= 2'd1) ? reg_load_1 : '0;
        rl_q[1]   <= (cnt_dec >= 2'd2) ? reg_load_2 : '0;
        rl_q[2]   <= (cnt_dec == 2'd3) ? reg_load_3 : '0;
        sel_q[0]  <= (cnt_dec >= 2'd1) ? select_1   : '0;
        sel_q[1]  <= (cnt_dec >= 2'd2) ? select_2   : '0;
        sel_q[2]  <= (cnt_dec == 2'd3) ? select_3   : '0;
        eip_hit_q <= 1'b0;
        // An illegal opcode retires as a 1-byte NOP, so its length is fixed here.
        len_q     <= (cnt_dec == 2'd0) ? LEN_W'(1) : '0;
      end else begin
        if (first_q && (state_q == S_STEP1))
          len_q <= num_of_ope;
        if (load_en && (cur_reg_load == EIP_CODE))
          eip_hit_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_micro_step_sequencer.sv
// Self-checking bench for micro_step_sequencer. Each instruction is expanded
// into an expected per-cycle output trace built from the step table, the stall
// pattern and the EIP-write rule. The DUT is then checked against that trace.
module tb_micro_step_sequencer;

  logic       clk2 = 1'b0;
  logic       reset;
  logic       fetch_valid;
  logic       fetch_ready;
  logic [7:0] ope1;
  logic [3:0] reg_load_1, reg_load_2, reg_load_3;
  logic [3:0] select_1, select_2, select_3;
  logic [3:0] num_of_ope;
  logic       stall;
  logic       load_en;
  logic [3:0] cur_reg_load, cur_select;
  logic [1:0] step_idx;
  logic       eip_inc_en;
  logic [3:0] eip_inc;
  logic       busy;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stl;
    logic [18:0] exp;
  } ent_t;

  logic [18:0] obs;
  assign obs = {fetch_ready, busy, load_en, cur_reg_load, cur_select, step_idx,
                eip_inc_en, eip_inc, illegal};

  micro_step_sequencer #(.STEP_W(4), .LEN_W(4), .EIP_CODE(4'h4)) dut (
    .clk2(clk2), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .ope1(ope1), .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
    .select_1(select_1), .select_2(select_2), .select_3(select_3),
    .num_of_ope(num_of_ope), .stall(stall), .load_en(load_en),
    .cur_reg_load(cur_reg_load), .cur_select(cur_select), .step_idx(step_idx),
    .eip_inc_en(eip_inc_en), .eip_inc(eip_inc), .busy(busy), .illegal(illegal)
  );

  always #5 clk2 = ~clk2;

  function automatic logic [18:0] pk(input logic fr, input logic bz, input logic le,
                                     input logic [3:0] rl, input logic [3:0] sl,
                                     input logic [1:0] idx, input logic ee,
                                     input logic [3:0] inc, input logic ill);
    return {fr, bz, le, rl, sl, idx, ee, inc, ill};
  endfunction

  function automatic int unsigned model_steps(input logic [7:0] op);
    case (op)
      8'h89, 8'hb8:               return 1;
      8'h55, 8'h5d, 8'hc3, 8'h6a: return 2;
      8'he2:                      return 3;
      default:                    return 0;
    endcase
  endfunction

  task automatic scramble_inputs();
    reg_load_1 = 4'($urandom); reg_load_2 = 4'($urandom); reg_load_3 = 4'($urandom);
    select_1   = 4'($urandom); select_2   = 4'($urandom); select_3   = 4'($urandom);
    ope1       = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk2);
    reset = 1'b1;
    @(negedge clk2);
    reset = 1'b0;
  endtask

  // Presents one instruction and checks every cycle until the sequencer is idle again.
  task automatic run_instr(input string nm, input logic [7:0] op,
                           input logic [2:0][3:0] rl, input logic [2:0][3:0] sl,
                           input logic [3:0] len,
                           input int unsigned st1, input int unsigned st2,
                           input int unsigned st3);
    ent_t        q[$];
    int unsigned n;
    int unsigned st[3];
    bit          hit;
    st[0] = st1; st[1] = st2; st[2] = st3;
    n   = model_steps(op);
    hit = 1'b0;
    @(negedge clk2);
    fetch_valid = 1'b1;
    ope1        = op;
    reg_load_1  = (n >= 1) ? rl[0] : 4'bx;
    reg_load_2  = (n >= 2) ? rl[1] : 4'bx;
    reg_load_3  = (n >= 3) ? rl[2] : 4'bx;
    select_1    = (n >= 1) ? sl[0] : 4'bx;
    select_2    = (n >= 2) ? sl[1] : 4'bx;
    select_3    = (n >= 3) ? sl[2] : 4'bx;
    stall       = 1'($urandom);
    num_of_ope  = 4'($urandom);
    #1;
    total++;
    if (obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL %s accept_idle got=%h exp=%h", nm, obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    if (n == 0) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++)
        q.push_back('{stl: 1'($urandom), exp: pk(0, 1, 0, 0, 0, 0, 0, 0, 1)});
`else
      q.push_back('{stl: 1'($urandom), exp: pk(0, 1, 0, 0, 0, 0, 1, 4'd1, 1)});
      q.push_back('{stl: 1'($urandom), exp: pk(1, 0, 0, 0, 0, 0, 0, 0, 0)});
`endif
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        for (int s = 0; s < int'(st[k]); s++)
          q.push_back('{stl: 1'b1, exp: pk(0, 1, 0, rl[k], sl[k], 2'(k + 1), 0, 0, 0)});
        q.push_back('{stl: 1'b0, exp: pk(0, 1, 1, rl[k], sl[k], 2'(k + 1), 0, 0, 0)});
        if (rl[k] == 4'h4) hit = 1'b1;
      end
      q.push_back('{stl: 1'($urandom), exp: pk(0, 1, 0, 0, 0, 0, !hit, len, 0)});
      q.push_back('{stl: 1'($urandom), exp: pk(1, 0, 0, 0, 0, 0, 0, 0, 0)});
    end
    foreach (q[i]) begin
      @(negedge clk2);
      fetch_valid = 1'b0;
      stall       = q[i].stl;
      num_of_ope  = (i == 0) ? len : 4'($urandom);
      scramble_inputs();
      #1;
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", nm, i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_valid = 1'b0; stall = 1'b0; num_of_ope = '0;
    scramble_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk2);
      fetch_valid = 1'($urandom);
      stall       = 1'($urandom);
      ope1        = 8'h89;
      #1;
      total++;
      if (obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        bad++;
        $display("FAIL reset_state got=%h exp=%h", obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    @(negedge clk2);
    reset = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_single_step();
    run_instr("single_89", 8'h89, {4'h0, 4'h0, 4'h2}, {4'h0, 4'h0, 4'h2}, 4'd2, 0, 0, 0);
    run_instr("single_b8", 8'hb8, {4'h0, 4'h0, 4'h4}, {4'h0, 4'h0, 4'h7}, 4'd3, 2, 0, 0);
  endtask

  task automatic test_stall();
    run_instr("stall_55", 8'h55, {4'h0, 4'h1, 4'h3}, {4'h0, 4'h1, 4'h5}, 4'd1, 0, 3, 0);
  endtask

  task automatic test_three_step();
    run_instr("three_e2", 8'he2, {4'h4, 4'h1, 4'h1}, {4'h2, 4'h3, 4'h2}, 4'd5, 0, 0, 0);
  endtask

  task automatic test_eip_hit();
    run_instr("eiphit_c3", 8'hc3, {4'h0, 4'h9, 4'h4}, {4'h0, 4'h6, 4'h1}, 4'd1, 1, 1, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_ff", 8'hff, {4'h0, 4'h0, 4'h4}, {4'h0, 4'h0, 4'h4}, 4'd7, 0, 0, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    do_reset();
`endif
    run_instr("after_illegal", 8'h5d, {4'h0, 4'h2, 4'h3}, {4'h0, 4'h8, 4'h9}, 4'd2, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk2);
    fetch_valid = 1'b1; ope1 = 8'h6a; stall = 1'b0;
    reg_load_1 = 4'h3; select_1 = 4'h5; reg_load_2 = 4'h6; select_2 = 4'h7;
    @(negedge clk2);
    fetch_valid = 1'b0; num_of_ope = 4'd2; stall = 1'b0;
    scramble_inputs();
    #1;
    total++;
    if (obs !== pk(0, 1, 1, 4'h3, 4'h5, 2'd1, 0, 0, 0)) begin
      bad++;
      $display("FAIL rstmid_step1 got=%h exp=%h", obs, pk(0, 1, 1, 4'h3, 4'h5, 2'd1, 0, 0, 0));
    end
    @(negedge clk2);
    stall = 1'b1;
    #1;
    total++;
    if (obs !== pk(0, 1, 0, 4'h6, 4'h7, 2'd2, 0, 0, 0)) begin
      bad++;
      $display("FAIL rstmid_step2 got=%h exp=%h", obs, pk(0, 1, 0, 4'h6, 4'h7, 2'd2, 0, 0, 0));
    end
    stall = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL rstmid_async got=%h exp=%h", obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk2);
      if (i == 1) reset = 1'b0;
      stall = 1'($urandom);
      #1;
      total++;
      if (obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        bad++;
        $display("FAIL rstmid_idle cyc=%0d got=%h exp=%h", i, obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]       op;
    logic [7:0]       ops [8];
    logic [2:0][3:0]  rl, sl;
    ops = '{8'h89, 8'hb8, 8'h55, 8'h5d, 8'hc3, 8'h6a, 8'he2, 8'h00};
    for (int t = 0; t < 60; t++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 8'h00) op = 8'($urandom);
      rl = 12'($urandom);
      sl = 12'($urandom);
      run_instr("random", op, rl, sl, 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (model_steps(op) == 0) do_reset();
`endif
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_a", 8'h6a, {4'h0, 4'h4, 4'h1}, {4'h0, 4'h2, 4'h3}, 4'd9, 0, 0, 0);
    run_instr("b2b_b", 8'he2, {4'h5, 4'h6, 4'h7}, {4'h8, 4'h9, 4'ha}, 4'd15, 1, 0, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_stall();
    test_three_step();
    test_eip_hit();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
